// File: rtl/radiometer_pkg.sv
// Shared definitions for the Dicke-switched radiometer demodulator.
// Macro DICKE_DEMOD_BLANKING_EN adds the BLANK state to the state encoding.
package radiometer_pkg;

  localparam int DEFAULT_SAMPLE_W = 12;
  localparam int DEFAULT_CNT_W    = 16;

  typedef enum logic [1:0] {
    ALIGN   = 2'd0,
`ifdef DICKE_DEMOD_BLANKING_EN
    BLANK   = 2'd1,
`endif
    ACCUM   = 2'd2,
    PUBLISH = 2'd3
  } demod_state_t;

  // Signed difference of two unsigned accumulators needs one extra bit.
  function automatic int result_width(input int sample_w, input int cnt_w);
    return sample_w + cnt_w + 1;
  endfunction

endpackage

// File: rtl/switch_edge_sync.sv
// Two-flop synchronizer for the looped-back Dicke switch drive, plus
// single-cycle rise/fall pulses on the synchronized level.
module switch_edge_sync (
  input  logic clk,
  input  logic clr,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic stable;
  logic stable_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta     <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      meta     <= async_in;
      stable   <= meta;
      stable_d <= stable;
    end
  end

  assign level = stable;
  assign rise  = stable & ~stable_d;
  assign fall  = ~stable & stable_d;

endmodule

// File: rtl/dicke_sync_demodulator.sv
// Synchronous Dicke demodulator: integrates antenna and reference samples over
// PERIODS switch periods and publishes their difference. Blanking after switch
// edges is built only when DICKE_DEMOD_BLANKING_EN is defined.
module dicke_sync_demodulator
  import radiometer_pkg::*;
#(
  parameter int SAMPLE_W      = DEFAULT_SAMPLE_W,
  parameter int CNT_W         = DEFAULT_CNT_W,
  parameter int PERIODS       = 16,
  parameter int BLANK_SAMPLES = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         switch_signal,
  input  logic                         sample_valid,
  input  logic [SAMPLE_W-1:0]          sample,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic signed [SAMPLE_W+CNT_W:0] result,
  output logic                         overrun
);

  localparam int              ACC_W     = SAMPLE_W + CNT_W;
  localparam int              RES_W     = result_width(SAMPLE_W, CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Edges alternate, so the window closes on rising edge number 2*PERIODS-1.
  localparam logic [8:0]      LAST_EDGE = 9'(2 * PERIODS - 1);

  if (PERIODS < 1 || PERIODS > 255 || BLANK_SAMPLES < 0 || BLANK_SAMPLES > 15) begin : g_param_check
    $error("dicke_sync_demodulator: PERIODS or BLANK_SAMPLES out of range");
  end

`ifdef DICKE_DEMOD_BLANKING_EN
  localparam logic [3:0]   BLANK_LAST = 4'(BLANK_SAMPLES - 1);
  localparam demod_state_t AFTER_EDGE = (BLANK_SAMPLES == 0) ? ACCUM : BLANK;
  logic [3:0] blank_cnt;
`else
  localparam demod_state_t AFTER_EDGE = ACCUM;
`endif

  demod_state_t            state;
  logic                    sw_level;
  logic                    sw_rise;
  logic                    sw_fall;
  logic                    sw_edge;
  logic                    closing_edge;
  logic                    take_sample;
  logic                    publish_ok;
  logic [ACC_W-1:0]        sum_ant;
  logic [ACC_W-1:0]        sum_ref;
  logic [ACC_W-1:0]        ant_base;
  logic [ACC_W-1:0]        ref_base;
  logic [CNT_W-1:0]        cnt_ant;
  logic [CNT_W-1:0]        cnt_ref;
  logic [CNT_W-1:0]        cnt_ant_base;
  logic [CNT_W-1:0]        cnt_ref_base;
  logic [8:0]              edge_cnt;
  logic signed [RES_W-1:0] diff;

  switch_edge_sync u_switch_edge_sync (
    .clk      (clk),
    .clr      (clr),
    .async_in (switch_signal),
    .level    (sw_level),
    .rise     (sw_rise),
    .fall     (sw_fall)
  );

  // PUBLISH restarts the window, so a sample taken that cycle starts from zero.
  always_comb begin
    sw_edge      = sw_rise | sw_fall;
    closing_edge = sw_rise && (edge_cnt == LAST_EDGE);
    publish_ok   = !result_valid || result_ready;
    diff         = $signed({1'b0, sum_ant}) - $signed({1'b0, sum_ref});
    ant_base     = (state == PUBLISH) ? '0 : sum_ant;
    ref_base     = (state == PUBLISH) ? '0 : sum_ref;
    cnt_ant_base = (state == PUBLISH) ? '0 : cnt_ant;
    cnt_ref_base = (state == PUBLISH) ? '0 : cnt_ref;
`ifdef DICKE_DEMOD_BLANKING_EN
    take_sample  = sample_valid && (state == ACCUM) && !sw_edge;
`else
    take_sample  = sample_valid && ((state == ACCUM) || (state == PUBLISH));
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= ALIGN;
      sum_ant      <= '0;
      sum_ref      <= '0;
      cnt_ant      <= '0;
      cnt_ref      <= '0;
      edge_cnt     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
`ifdef DICKE_DEMOD_BLANKING_EN
      blank_cnt    <= '0;
`endif
    end else begin
      if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end

      unique case (state)
        ALIGN: begin
          if (sw_rise) begin
            edge_cnt <= '0;
            sum_ant  <= '0;
            sum_ref  <= '0;
            cnt_ant  <= '0;
            cnt_ref  <= '0;
            state    <= AFTER_EDGE;
`ifdef DICKE_DEMOD_BLANKING_EN
            blank_cnt <= '0;
`endif
          end
        end

`ifdef DICKE_DEMOD_BLANKING_EN
        BLANK: begin
          if (closing_edge) begin
            state <= PUBLISH;
          end else if (sw_edge) begin
            edge_cnt  <= edge_cnt + 1'b1;
            blank_cnt <= '0;
          end else if (sample_valid) begin
            blank_cnt <= blank_cnt + 1'b1;
            if (blank_cnt == BLANK_LAST) begin
              state <= ACCUM;
            end
          end
        end
`endif

        ACCUM: begin
          if (closing_edge) begin
            state <= PUBLISH;
          end else if (sw_edge) begin
            edge_cnt <= edge_cnt + 1'b1;
`ifdef DICKE_DEMOD_BLANKING_EN
            blank_cnt <= '0;
            state     <= AFTER_EDGE;
`endif
          end
        end

        PUBLISH: begin
          if (publish_ok) begin
            result       <= diff;
            result_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          edge_cnt <= '0;
          sum_ant  <= '0;
          sum_ref  <= '0;
          cnt_ant  <= '0;
          cnt_ref  <= '0;
          state    <= AFTER_EDGE;
`ifdef DICKE_DEMOD_BLANKING_EN
          blank_cnt <= '0;
`endif
        end

        default: state <= ALIGN;
      endcase

      // A saturated phase stops accumulating for the rest of the window.
      if (take_sample) begin
        if (sw_level) begin
          if (cnt_ant_base == CNT_MAX) begin
            overrun <= 1'b1;
          end else begin
            sum_ant <= ant_base + ACC_W'(sample);
            cnt_ant <= cnt_ant_base + 1'b1;
          end
        end else begin
          if (cnt_ref_base == CNT_MAX) begin
            overrun <= 1'b1;
          end else begin
            sum_ref <= ref_base + ACC_W'(sample);
            cnt_ref <= cnt_ref_base + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dicke_sync_demodulator.sv
// Scoreboard bench for dicke_sync_demodulator; the reference model integrates
// whole half-periods arithmetically and honours DICKE_DEMOD_BLANKING_EN.
module tb_dicke_sync_demodulator;

  localparam int SAMPLE_W      = 12;
  localparam int CNT_W         = 6;
  localparam int PERIODS       = 2;
  localparam int BLANK_SAMPLES = 3;
  localparam int RES_W         = SAMPLE_W + CNT_W + 1;
  localparam int CNT_LIMIT     = (1 << CNT_W) - 1;
`ifdef DICKE_DEMOD_BLANKING_EN
  localparam int DROP_N = BLANK_SAMPLES;
`else
  localparam int DROP_N = 0;
`endif

  logic                    clk;
  logic                    clr;
  logic                    switch_signal;
  logic                    sample_valid;
  logic [SAMPLE_W-1:0]     sample;
  logic                    result_valid;
  logic                    result_ready;
  logic signed [RES_W-1:0] result;
  logic                    overrun;

  dicke_sync_demodulator #(
    .SAMPLE_W      (SAMPLE_W),
    .CNT_W         (CNT_W),
    .PERIODS       (PERIODS),
    .BLANK_SAMPLES (BLANK_SAMPLES)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .switch_signal (switch_signal),
    .sample_valid  (sample_valid),
    .sample        (sample),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result        (result),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint value;
    bit     ovr;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;

  bit     aligned;
  bit     cur_level;
  int     rises_seen;
  longint m_ant;
  longint m_ref;
  int     m_cnt_ant;
  int     m_cnt_ref;
  bit     m_ovr;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_clear_window();
    m_ant = 0; m_ref = 0; m_cnt_ant = 0; m_cnt_ref = 0; rises_seen = 0;
  endtask

  // One result per PERIODS rising edges; a held, unaccepted result blocks the new one.
  task automatic model_publish();
    exp_t e, last;
    e.value = m_ant - m_ref;
    if (sb_q.size() > 0) begin
      m_ovr = 1'b1;
      last = sb_q.pop_back();
      last.ovr = 1'b1;
      sb_q.push_back(last);
    end else begin
      e.ovr = m_ovr;
      sb_q.push_back(e);
    end
    model_clear_window();
  endtask

  task automatic model_switch(input bit new_level);
    if (new_level != cur_level && new_level) begin
      if (!aligned) begin
        aligned = 1'b1;
        model_clear_window();
      end else begin
        rises_seen++;
        if (rises_seen == PERIODS) model_publish();
      end
    end
    cur_level = new_level;
  endtask

  task automatic model_sample(input int k, input bit level, input int v);
    if (!aligned || k < DROP_N) return;
    if (level) begin
      if (m_cnt_ant == CNT_LIMIT) m_ovr = 1'b1;
      else begin m_ant += v; m_cnt_ant++; end
    end else begin
      if (m_cnt_ref == CNT_LIMIT) m_ovr = 1'b1;
      else begin m_ref += v; m_cnt_ref++; end
    end
  endtask

  // One switch half-period of n samples, spaced away from the edge; optional clr pulse.
  task automatic apply_stimulus(input bit level, input int n, input bit rnd, input int val, input int clr_at);
    int h;
    int v;
    model_switch(level);
    switch_signal = level;
    h = 4 * n + 8;
    for (int c = 0; c < h; c++) begin
      sample_valid = 1'b0;
      clr = 1'b0;
      if (c == clr_at) begin
        clr = 1'b1;
      end else if (c >= 4 && (c % 4) == 0 && (c / 4 - 1) < n) begin
        v = rnd ? int'($urandom_range(0, (1 << SAMPLE_W) - 1)) : val;
        sample = SAMPLE_W'(v);
        sample_valid = 1'b1;
        model_sample(c / 4 - 1, level, v);
      end
      @(posedge clk);
      #1;
      if (c == clr_at) begin
        aligned = 1'b0;
        m_ovr = 1'b0;
        model_clear_window();
        check_output("clr_result_valid", longint'(result_valid), 0);
        check_output("clr_overrun", longint'(overrun), 0);
      end
    end
    sample_valid = 1'b0;
    clr = 1'b0;
  endtask

  task automatic run_window(input bit rnd, input int n_ant, input int v_ant, input int n_ref, input int v_ref);
    for (int p = 0; p < PERIODS; p++) begin
      apply_stimulus(1'b1, rnd ? int'($urandom_range(4, 14)) : n_ant, rnd, v_ant, -1);
      apply_stimulus(1'b0, rnd ? int'($urandom_range(4, 14)) : n_ref, rnd, v_ref, -1);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold stability.
  exp_t   mon_e;
  bit     prev_hold = 1'b0;
  longint prev_result = 0;

  always @(negedge clk) begin
    if (clr) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && result_valid)
        check_output("hold_stable", longint'(result), prev_result);
      if (result_valid && result_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got %0d, expected no result", longint'(result));
        end else begin
          mon_e = sb_q.pop_front();
          check_output("result", longint'(result), mon_e.value);
          check_output("overrun_at_result", longint'(overrun), longint'(mon_e.ovr));
        end
      end
      prev_hold   = result_valid && !result_ready;
      prev_result = longint'(result);
    end
  end

  initial begin
    clr = 1'b1;
    switch_signal = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    result_ready = 1'b1;
    aligned = 1'b0;
    cur_level = 1'b0;
    m_ovr = 1'b0;
    model_clear_window();

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_result_valid", longint'(result_valid), 0);
    check_output("reset_result", longint'(result), 0);
    check_output("reset_overrun", longint'(overrun), 0);
    clr = 1'b0;

    apply_stimulus(1'b0, 8, 1'b0, 0, -1);
    run_window(1'b0, 16, 100, 16, 100);
    run_window(1'b0, 16, 300, 16, 200);
    for (int w = 0; w < 5; w++) run_window(1'b1, 0, 0, 0, 0);

    // Antenna phase saturates the 6-bit counter.
    run_window(1'b1, 40, 0, 6, 0);
    for (int p = 0; p < PERIODS; p++) begin
      apply_stimulus(1'b1, 40, 1'b0, 1, -1);
      apply_stimulus(1'b0, 5, 1'b1, 0, -1);
    end

    // clr mid-window during the reference phase, then realign.
    apply_stimulus(1'b1, 10, 1'b1, 0, -1);
    apply_stimulus(1'b0, 12, 1'b1, 0, 21);
    run_window(1'b1, 0, 0, 0, 0);
    run_window(1'b1, 0, 0, 0, 0);

    // Downstream stalls across two windows.
    result_ready = 1'b0;
    run_window(1'b1, 0, 0, 0, 0);
    run_window(1'b1, 0, 0, 0, 0);
    apply_stimulus(1'b1, 8, 1'b1, 0, -1);
    check_output("stall_result_valid", longint'(result_valid), 1);
    check_output("stall_overrun", longint'(overrun), 1);
    result_ready = 1'b1;
    apply_stimulus(1'b0, 8, 1'b1, 0, -1);
    run_window(1'b1, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4, 1'b1, 0, -1);
    apply_stimulus(1'b0, 4, 1'b1, 0, -1);

    for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(posedge clk);
    check_output("pending_results_drained", longint'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
